// File: rtl/banked_mem_ctrl.sv
// Multi-bank single-port memory controller: valid/ready requests, broadcast write,
// tagged one-cycle read return, out-of-range bank flag and a full-array clear engine.
module banked_mem_ctrl #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 10,
  parameter int NUM_BANKS = 4,
  parameter int SEL_W     = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic              req_bcast,
  input  logic [SEL_W-1:0]  req_bank,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic [SEL_W-1:0]  rd_bank,
  output logic              rd_err,
  input  logic              clr_start,
  output logic              clr_busy,
  output logic              clr_done
);

  localparam int DEPTH  = 2 ** ADDR_W;
  localparam int BIDX_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam logic [SEL_W:0] NB_L = (SEL_W + 1)'(NUM_BANKS);

  typedef enum logic {ST_CLEAR, ST_IDLE} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   clr_addr_q, clr_addr_d;
  logic                clr_done_q, clr_done_d;
  logic                rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;
  logic [SEL_W-1:0]    rd_bank_q, rd_bank_d;
  logic                rd_err_q, rd_err_d;

  logic [DATA_W-1:0]   mem [NUM_BANKS][DEPTH];
  logic [NUM_BANKS-1:0] mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;

  logic                accept;
  logic                bank_ok;
  logic                clr_last;
  logic [BIDX_W-1:0]   bidx;

  assign req_ready = (state_q == ST_IDLE);
  assign clr_busy  = (state_q == ST_CLEAR);
  assign accept    = req_valid && req_ready;
  assign bank_ok   = ({1'b0, req_bank} < NB_L);
  assign bidx      = req_bank[BIDX_W-1:0];
  assign clr_last  = &clr_addr_q;

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    clr_done_d = 1'b0;
    rd_valid_d = 1'b0;
    rd_data_d  = rd_data_q;
    rd_bank_d  = rd_bank_q;
    rd_err_d   = rd_err_q;
    mem_we     = '0;
    mem_addr   = req_addr;
    mem_wdata  = req_wdata;
    case (state_q)
      ST_CLEAR: begin
        mem_we     = '1;
        mem_addr   = clr_addr_q;
        mem_wdata  = '0;
        clr_addr_d = clr_addr_q + 1'b1;
        if (clr_last) begin
          state_d    = ST_IDLE;
          clr_done_d = 1'b1;
        end
      end
      ST_IDLE: begin
        if (clr_start) begin
          state_d    = ST_CLEAR;
          clr_addr_d = '0;
        end
        // An accepted request still completes in the cycle a clear is requested.
        if (accept) begin
          if (req_we) begin
            if (req_bcast)    mem_we = '1;
            else if (bank_ok) mem_we[bidx] = 1'b1;
          end else begin
            rd_valid_d = 1'b1;
            rd_bank_d  = req_bank;
            rd_err_d   = ~bank_ok;
            rd_data_d  = bank_ok ? mem[bidx][req_addr] : '0;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_CLEAR;
      clr_addr_q <= '0;
      clr_done_q <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      rd_bank_q  <= '0;
      rd_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      clr_done_q <= clr_done_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      rd_bank_q  <= rd_bank_d;
      rd_err_q   <= rd_err_d;
    end
  end

  // Bank storage: no reset, contents change only through requests or the clear sweep.
  always_ff @(posedge clk) begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (mem_we[b]) mem[b][mem_addr] <= mem_wdata;
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
  assign rd_bank  = rd_bank_q;
  assign rd_err   = rd_err_q;
  assign clr_done = clr_done_q;

endmodule

// File: tb/tb_banked_mem_ctrl.sv
// Bench for banked_mem_ctrl: a 4-bank and a 3-bank instance share one stimulus stream;
// read expectations go through a scoreboard queue checked when rd_valid is due.
module tb_banked_mem_ctrl;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int SW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_we = 1'b0;
  logic          req_bcast = 1'b0;
  logic [SW-1:0] req_bank = '0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          clr_start = 1'b0;

  logic          ready4, rv4, re4, busy4, done4;
  logic [DW-1:0] rd4;
  logic [SW-1:0] rb4;
  logic          ready3, rv3, re3, busy3, done3;
  logic [DW-1:0] rd3;
  logic [SW-1:0] rb3;

  always #5 clk = ~clk;

  banked_mem_ctrl #(.DATA_W(DW), .ADDR_W(AW), .NUM_BANKS(4), .SEL_W(SW)) u4 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(ready4),
    .req_we(req_we), .req_bcast(req_bcast), .req_bank(req_bank), .req_addr(req_addr),
    .req_wdata(req_wdata), .rd_valid(rv4), .rd_data(rd4), .rd_bank(rb4), .rd_err(re4),
    .clr_start(clr_start), .clr_busy(busy4), .clr_done(done4)
  );

  banked_mem_ctrl #(.DATA_W(DW), .ADDR_W(AW), .NUM_BANKS(3), .SEL_W(SW)) u3 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(ready3),
    .req_we(req_we), .req_bcast(req_bcast), .req_bank(req_bank), .req_addr(req_addr),
    .req_wdata(req_wdata), .rd_valid(rv3), .rd_data(rd3), .rd_bank(rb3), .rd_err(re3),
    .clr_start(clr_start), .clr_busy(busy3), .clr_done(done3)
  );

  typedef struct {
    logic       we;
    logic       bcast;
    logic [1:0] bank;
    logic [3:0] addr;
    logic [7:0] wdata;
    logic [7:0] d4;
    logic       e4;
    logic [7:0] d3;
    logic       e3;
  } vec_t;

  typedef struct {
    int         due;
    logic [7:0] d4;
    logic       e4;
    logic [7:0] d3;
    logic       e3;
    logic [1:0] bank;
  } exp_t;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  exp_t sbq[$];
  exp_t mon_e;
  vec_t vecs[18];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic vec_t mk(input logic we, input logic bc, input logic [1:0] b,
                              input logic [3:0] a, input logic [7:0] wd,
                              input logic [7:0] d4, input logic e4,
                              input logic [7:0] d3, input logic e3);
    vec_t v;
    v.we = we; v.bcast = bc; v.bank = b; v.addr = a; v.wdata = wd;
    v.d4 = d4; v.e4 = e4; v.d3 = d3; v.e3 = e3;
    return v;
  endfunction

  task automatic issue(input vec_t v);
    exp_t e;
    @(posedge clk); #1;
    chk("issue_ready4", {31'd0, ready4}, 32'd1);
    chk("issue_ready3", {31'd0, ready3}, 32'd1);
    req_valid = 1'b1;
    req_we    = v.we;
    req_bcast = v.bcast;
    req_bank  = v.bank;
    req_addr  = v.addr;
    req_wdata = v.wdata;
    if (!v.we) begin
      e.due = cyc + 1; e.d4 = v.d4; e.e4 = v.e4; e.d3 = v.d3; e.e3 = v.e3; e.bank = v.bank;
      sbq.push_back(e);
    end
  endtask

  task automatic idle();
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_bcast = 1'b0;
  endtask

  task automatic rst_vals(input string tag);
    chk({tag, "_busy4"},  {31'd0, busy4},  32'd1);
    chk({tag, "_ready4"}, {31'd0, ready4}, 32'd0);
    chk({tag, "_rv4"},    {31'd0, rv4},    32'd0);
    chk({tag, "_rd4"},    {24'd0, rd4},    32'd0);
    chk({tag, "_rb4"},    {30'd0, rb4},    32'd0);
    chk({tag, "_re4"},    {31'd0, re4},    32'd0);
    chk({tag, "_done4"},  {31'd0, done4},  32'd0);
    chk({tag, "_busy3"},  {31'd0, busy3},  32'd1);
    chk({tag, "_ready3"}, {31'd0, ready3}, 32'd0);
    chk({tag, "_rd3"},    {24'd0, rd3},    32'd0);
    chk({tag, "_rb3"},    {30'd0, rb3},    32'd0);
    chk({tag, "_done3"},  {31'd0, done3},  32'd0);
  endtask

  // Counts busy cycles from the next falling edge; optionally pokes clr_start mid-sweep.
  task automatic sweep_check(input string tag, input bit poke);
    int n;
    n = 0;
    @(negedge clk);
    while (busy4 && n < 100) begin
      n++;
      chk({tag, "_ready4_low"}, {31'd0, ready4}, 32'd0);
      chk({tag, "_busy3"},      {31'd0, busy3},  32'd1);
      chk({tag, "_done4_low"},  {31'd0, done4},  32'd0);
      clr_start = (poke && n == 5);
      @(negedge clk);
    end
    clr_start = 1'b0;
    chk({tag, "_busy_cycles"}, n, 32'd16);
    chk({tag, "_done4"},  {31'd0, done4},  32'd1);
    chk({tag, "_done3"},  {31'd0, done3},  32'd1);
    chk({tag, "_ready4"}, {31'd0, ready4}, 32'd1);
    chk({tag, "_ready3"}, {31'd0, ready3}, 32'd1);
    @(negedge clk);
    chk({tag, "_done4_end"}, {31'd0, done4}, 32'd0);
    chk({tag, "_done3_end"}, {31'd0, done3}, 32'd0);
  endtask

  always @(negedge clk) begin
    if (sbq.size() > 0 && sbq[0].due <= cyc) begin
      mon_e = sbq.pop_front();
      chk("rd_valid4", {31'd0, rv4}, 32'd1);
      chk("rd_data4",  {24'd0, rd4}, {24'd0, mon_e.d4});
      chk("rd_bank4",  {30'd0, rb4}, {30'd0, mon_e.bank});
      chk("rd_err4",   {31'd0, re4}, {31'd0, mon_e.e4});
      chk("rd_valid3", {31'd0, rv3}, 32'd1);
      chk("rd_data3",  {24'd0, rd3}, {24'd0, mon_e.d3});
      chk("rd_bank3",  {30'd0, rb3}, {30'd0, mon_e.bank});
      chk("rd_err3",   {31'd0, re3}, {31'd0, mon_e.e3});
    end else if (rv4 || rv3) begin
      total++;
      bad++;
      $display("FAIL rd_valid_unexpected actual=%b%b required=00 (t=%0t)", rv4, rv3, $time);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //              we    bc    bank  addr   wdata   d4     e4    d3     e3
    vecs[0]  = mk(1'b1, 1'b0, 2'd2, 4'd5,  8'hA5, 8'h00, 1'b0, 8'h00, 1'b0);
    vecs[1]  = mk(1'b0, 1'b0, 2'd2, 4'd5,  8'h00, 8'hA5, 1'b0, 8'hA5, 1'b0);
    vecs[2]  = mk(1'b0, 1'b0, 2'd1, 4'd5,  8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
    vecs[3]  = mk(1'b0, 1'b1, 2'd2, 4'd5,  8'h00, 8'hA5, 1'b0, 8'hA5, 1'b0);
    vecs[4]  = mk(1'b1, 1'b1, 2'd3, 4'd3,  8'h3C, 8'h00, 1'b0, 8'h00, 1'b0);
    vecs[5]  = mk(1'b0, 1'b0, 2'd0, 4'd3,  8'h00, 8'h3C, 1'b0, 8'h3C, 1'b0);
    vecs[6]  = mk(1'b0, 1'b0, 2'd1, 4'd3,  8'h00, 8'h3C, 1'b0, 8'h3C, 1'b0);
    vecs[7]  = mk(1'b0, 1'b0, 2'd2, 4'd3,  8'h00, 8'h3C, 1'b0, 8'h3C, 1'b0);
    vecs[8]  = mk(1'b0, 1'b0, 2'd3, 4'd3,  8'h00, 8'h3C, 1'b0, 8'h00, 1'b1);
    vecs[9]  = mk(1'b1, 1'b0, 2'd3, 4'd7,  8'h77, 8'h00, 1'b0, 8'h00, 1'b0);
    vecs[10] = mk(1'b0, 1'b0, 2'd3, 4'd7,  8'h00, 8'h77, 1'b0, 8'h00, 1'b1);
    vecs[11] = mk(1'b0, 1'b0, 2'd0, 4'd7,  8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
    vecs[12] = mk(1'b0, 1'b0, 2'd1, 4'd7,  8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
    vecs[13] = mk(1'b0, 1'b0, 2'd2, 4'd7,  8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
    vecs[14] = mk(1'b1, 1'b0, 2'd0, 4'd15, 8'hFF, 8'h00, 1'b0, 8'h00, 1'b0);
    vecs[15] = mk(1'b0, 1'b0, 2'd0, 4'd15, 8'h00, 8'hFF, 1'b0, 8'hFF, 1'b0);
    vecs[16] = mk(1'b1, 1'b0, 2'd1, 4'd0,  8'h01, 8'h00, 1'b0, 8'h00, 1'b0);
    vecs[17] = mk(1'b0, 1'b0, 2'd1, 4'd0,  8'h00, 8'h01, 1'b0, 8'h01, 1'b0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_vals("por");
    @(posedge clk); #1;
    rst_n = 1'b1;
    sweep_check("por_sweep", 1'b0);

    for (int b = 0; b < 4; b++) begin
      for (int a = 0; a < 16; a++) begin
        issue(mk(1'b0, 1'b0, 2'(b), 4'(a), 8'h00, 8'h00, 1'b0, 8'h00, (b == 3)));
      end
    end
    idle();

    for (int i = 0; i < 18; i++) issue(vecs[i]);
    idle();

    issue(mk(1'b0, 1'b0, 2'd0, 4'd3, 8'h00, 8'h3C, 1'b0, 8'h3C, 1'b0));
    clr_start = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    clr_start = 1'b0;
    sweep_check("cmd_sweep", 1'b1);
    issue(mk(1'b0, 1'b0, 2'd0, 4'd3, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0));
    issue(mk(1'b0, 1'b0, 2'd2, 4'd5, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0));
    issue(mk(1'b0, 1'b0, 2'd3, 4'd3, 8'h00, 8'h00, 1'b0, 8'h00, 1'b1));
    issue(mk(1'b0, 1'b0, 2'd0, 4'd15, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0));
    idle();

    issue(mk(1'b1, 1'b1, 2'd0, 4'd2, 8'h55, 8'h00, 1'b0, 8'h00, 1'b0));
    issue(mk(1'b0, 1'b0, 2'd2, 4'd2, 8'h00, 8'h55, 1'b0, 8'h55, 1'b0));
    idle();
    @(posedge clk); #1;
    clr_start = 1'b1;
    @(posedge clk); #1;
    clr_start = 1'b0;
    repeat (8) @(negedge clk);
    chk("mid_busy4", {31'd0, busy4}, 32'd1);
    chk("mid_rd4_held", {24'd0, rd4}, 32'h55);
    #2;
    rst_n = 1'b0;
    #1;
    rst_vals("mid_rst");
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    sweep_check("rst_sweep", 1'b0);
    issue(mk(1'b0, 1'b0, 2'd2, 4'd2, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0));
    issue(mk(1'b0, 1'b0, 2'd0, 4'd2, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0));
    idle();

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sbq.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
